// File: rtl/gtx_pkg.sv
// rtl/gtx_pkg.sv - shared constants and FSM state type for the GTX receive aligner
package gtx_pkg;

    localparam logic [7:0] K28_5   = 8'hBC;
    localparam logic [7:0] IDLE_HI = 8'h50;

    localparam int LOCK_CNT_DEF = 4;
    localparam int ERR_MAX_DEF  = 8;
    localparam int TIMEOUT_DEF  = 1024;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } rx_state_t;

endpackage

// File: rtl/gtx_rx_align.sv
// rtl/gtx_rx_align.sv - comma detection and byte realignment of the raw 16-bit rx word
module gtx_rx_align
    import gtx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  ctrl,
    input  logic [15:0] data,
    input  logic [1:0]  err,
    input  logic        offset,
    output logic        lo_hit,
    output logic        hi_hit,
    output logic [1:0]  al_ctrl,
    output logic [1:0]  al_err,
    output logic [15:0] al_data_q
);

    logic [15:0] prev_data;
    logic [1:0]  prev_ctrl;
    logic [1:0]  prev_err;
    logic [15:0] al_data;

    // A comma in both bytes is treated as a high-byte hit only.
    assign hi_hit = ctrl[1] && (data[15:8] == K28_5);
    assign lo_hit = ctrl[0] && (data[7:0] == K28_5) && !hi_hit;

    // Offset 1 pairs the previous high byte with the current low byte.
    assign al_data = offset ? {data[7:0], prev_data[15:8]} : prev_data;
    assign al_ctrl = offset ? {ctrl[0], prev_ctrl[1]}      : prev_ctrl;
    assign al_err  = offset ? {err[0], prev_err[1]}        : prev_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_data <= 16'h0000;
            prev_ctrl <= 2'b00;
            prev_err  <= 2'b00;
            al_data_q <= 16'h0000;
        end else begin
            prev_data <= data;
            prev_ctrl <= ctrl;
            prev_err  <= err;
            al_data_q <= al_data;
        end
    end

endmodule

// File: rtl/gtx_rx.sv
// rtl/gtx_rx.sv - GTX receive word aligner with HUNT/CHECK/LOCKED comma lock FSM
module gtx_rx
    import gtx_pkg::*;
#(
    parameter int LOCK_CNT = LOCK_CNT_DEF,
    parameter int ERR_MAX  = ERR_MAX_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
)(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  ctrl_i,
    input  logic [15:0] data_i,
    input  logic [1:0]  err_i,
    output logic [15:0] data_o,
    output logic        valid_o,
    output logic        link_o
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int EW = $clog2(ERR_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    rx_state_t       state, state_n;
    logic            offset, offset_n;
    logic [GW-1:0]   good_cnt, good_n;
    logic [EW-1:0]   err_cnt, err_n;
    logic [TW-1:0]   to_cnt, to_n;
    logic            lo_hit, hi_hit, hit_any, al_hit, other_hit, al_bad;
    logic [1:0]      al_ctrl, al_err;
    logic            link_d, valid_d;

    gtx_rx_align u_align (
        .clk       (clk_i),
        .rst       (rst_i),
        .ctrl      (ctrl_i),
        .data      (data_i),
        .err       (err_i),
        .offset    (offset),
        .lo_hit    (lo_hit),
        .hi_hit    (hi_hit),
        .al_ctrl   (al_ctrl),
        .al_err    (al_err),
        .al_data_q (data_o)
    );

    assign hit_any   = lo_hit | hi_hit;
    assign al_hit    = offset ? hi_hit : lo_hit;
    assign other_hit = offset ? lo_hit : hi_hit;
    assign al_bad    = other_hit | (|al_err);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_HUNT;
            offset   <= 1'b0;
            good_cnt <= '0;
            err_cnt  <= '0;
            to_cnt   <= '0;
            link_o   <= 1'b0;
            valid_o  <= 1'b0;
        end else begin
            state    <= state_n;
            offset   <= offset_n;
            good_cnt <= good_n;
            err_cnt  <= err_n;
            to_cnt   <= to_n;
            link_o   <= link_d;
            valid_o  <= valid_d;
        end
    end

    always_comb begin
        state_n  = state;
        offset_n = offset;
        good_n   = good_cnt;
        err_n    = err_cnt;
        to_n     = to_cnt;
        case (state)
            ST_HUNT: begin
                good_n = '0;
                err_n  = '0;
                to_n   = '0;
                if (hit_any) begin
                    state_n  = ST_CHECK;
                    offset_n = hi_hit;
                    good_n   = GW'(1);
                end
            end
            ST_CHECK: begin
                // Any disagreement restarts the count; a fresh comma restarts it at one.
                if (other_hit || (|err_i)) begin
                    if (hit_any) begin
                        state_n  = ST_CHECK;
                        offset_n = hi_hit;
                        good_n   = GW'(1);
                    end else begin
                        state_n = ST_HUNT;
                        good_n  = '0;
                    end
                end else if (al_hit) begin
                    if (good_cnt == GW'(LOCK_CNT - 1)) begin
                        state_n = ST_LOCKED;
                        good_n  = '0;
                        err_n   = '0;
                        to_n    = '0;
                    end else begin
                        good_n = good_cnt + 1'b1;
                    end
                end
            end
            ST_LOCKED: begin
                // An error on the same word as a good comma still counts as an error.
                if (al_bad) begin
                    if (err_cnt != EW'(ERR_MAX - 1))
                        err_n = err_cnt + 1'b1;
                end else if (al_hit) begin
                    err_n = '0;
                end
                to_n = al_hit ? '0 : to_cnt + 1'b1;
                if ((al_bad && err_cnt == EW'(ERR_MAX - 1)) ||
                    (!al_hit && to_cnt == TW'(TIMEOUT - 1))) begin
                    state_n = ST_HUNT;
                    err_n   = '0;
                    to_n    = '0;
                end
            end
            default: begin
                state_n = ST_HUNT;
                good_n  = '0;
                err_n   = '0;
                to_n    = '0;
            end
        endcase
    end

    // Both outputs sample the same state register, so they fall together.
    always_comb begin
        link_d  = (state == ST_LOCKED);
        valid_d = link_d && (al_ctrl == 2'b00) && (al_err == 2'b00);
    end

endmodule

// File: tb/tb_gtx_rx.sv
// tb/tb_gtx_rx.sv - self-checking scoreboard bench for gtx_rx
module tb_gtx_rx;
    import gtx_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [1:0]  ctrl_i = 2'b00;
    logic [15:0] data_i = 16'h0000;
    logic [1:0]  err_i = 2'b00;
    logic [15:0] data_o;
    logic        valid_o;
    logic        link_o;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    gtx_rx dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .ctrl_i  (ctrl_i),
        .data_i  (data_i),
        .err_i   (err_i),
        .data_o  (data_o),
        .valid_o (valid_o),
        .link_o  (link_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_i) begin
            if (valid_o) begin
                if (sb.size() == 0) begin
                    chk("valid_spurious", valid_o, 1'b0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("data_o", data_o, mon_e.data);
                    chk("latency", cyc, mon_e.due);
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                mon_e = sb.pop_front();
                chk("valid_missing", valid_o, 1'b1);
            end
        end
    end

    task automatic put(input logic [1:0] c, input logic [15:0] d, input logic [1:0] e);
        ctrl_i = c;
        data_i = d;
        err_i  = e;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [15:0] d);
        exp_t x;
        x.data = d;
        x.due  = cyc + 2;
        sb.push_back(x);
    endtask

    task automatic idle0(input int n);
        repeat (n) put(2'b01, {IDLE_HI, K28_5}, 2'b00);
    endtask

    task automatic idle1(input int n);
        repeat (n) put(2'b10, {K28_5, IDLE_HI}, 2'b00);
    endtask

    task automatic do_reset();
        ctrl_i = 2'b00;
        data_i = 16'h0000;
        err_i  = 2'b00;
        rst_i  = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        // Reset values
        @(posedge clk);
        #1;
        chk("rst_link", link_o, 1'b0);
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_data", data_o, 16'h0000);
        rst_i = 1'b0;

        // Offset 0 lock on idles, then payload
        idle0(4);
        chk("lock0_early", link_o, 1'b0);
        expect_word(16'hDEAD);
        put(2'b00, 16'hDEAD, 2'b00);
        chk("lock0", link_o, 1'b1);
        idle0(1);
        expect_word(16'h1234);
        put(2'b00, 16'h1234, 2'b00);
        expect_word(16'h5678);
        put(2'b00, 16'h5678, 2'b00);
        idle0(2);

        // Offset 1 lock and split payload reassembly
        do_reset();
        idle1(4);
        chk("lock1_early", link_o, 1'b0);
        expect_word(16'hDEAD);
        put(2'b00, {8'hAD, IDLE_HI}, 2'b00);
        chk("lock1", link_o, 1'b1);
        expect_word(16'hBEEF);
        put(2'b00, 16'hEFDE, 2'b00);
        put(2'b10, {K28_5, 8'hBE}, 2'b00);
        idle1(2);

        // Offset jump during CHECK re-latches at count one
        do_reset();
        idle0(2);
        put(2'b10, {K28_5, 8'h00}, 2'b00);
        chk("jump_link0", link_o, 1'b0);
        idle1(2);
        chk("jump_link1", link_o, 1'b0);
        idle1(1);
        chk("jump_link2", link_o, 1'b0);
        idle1(1);
        chk("jump_lock", link_o, 1'b1);

        // Seven errors then a clean comma leave the link up
        do_reset();
        idle0(5);
        repeat (7) put(2'b00, 16'h1234, 2'b01);
        idle0(2);
        chk("err7_hold_a", link_o, 1'b1);
        repeat (7) put(2'b00, 16'h1234, 2'b01);
        idle0(2);
        chk("err7_hold_b", link_o, 1'b1);
        // A comma coinciding with the seventh error does not clear the count
        repeat (7) put(2'b00, 16'h1234, 2'b01);
        idle0(1);
        put(2'b00, 16'h1234, 2'b01);
        put(2'b00, 16'h1111, 2'b00);
        chk("err_coincide_pre", link_o, 1'b1);
        put(2'b00, 16'h2222, 2'b00);
        chk("err_coincide_drop", link_o, 1'b0);

        // Eight errors drop the link
        do_reset();
        idle0(5);
        repeat (8) put(2'b00, 16'h1234, 2'b01);
        put(2'b00, 16'h3333, 2'b00);
        chk("err8_pre", link_o, 1'b1);
        put(2'b00, 16'h4444, 2'b00);
        chk("err8_drop", link_o, 1'b0);

        // Timeout boundary
        do_reset();
        idle0(4);
        for (int p = 1; p <= 1023; p++) begin
            expect_word(16'(p));
            put(2'b00, 16'(p), 2'b00);
        end
        idle0(1);
        chk("to1023_hold_a", link_o, 1'b1);
        idle0(2);
        chk("to1023_hold_b", link_o, 1'b1);
        for (int p = 1; p <= 1024; p++) begin
            if (p <= 1023)
                expect_word(16'h8000 + 16'(p));
            put(2'b00, 16'h8000 + 16'(p), 2'b00);
        end
        chk("to1024_pre", link_o, 1'b1);
        put(2'b00, 16'h0000, 2'b00);
        chk("to1024_drop", link_o, 1'b0);

        // Asynchronous reset mid-payload, then relock
        do_reset();
        idle0(4);
        expect_word(16'hA1A1);
        put(2'b00, 16'hA1A1, 2'b00);
        expect_word(16'hA2A2);
        put(2'b00, 16'hA2A2, 2'b00);
        put(2'b00, 16'hA3A3, 2'b00);
        @(negedge clk);
        #1;
        chk("pre_rst_link", link_o, 1'b1);
        rst_i = 1'b1;
        #1;
        chk("arst_data", data_o, 16'h0000);
        chk("arst_valid", valid_o, 1'b0);
        chk("arst_link", link_o, 1'b0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        idle0(4);
        chk("relock_early", link_o, 1'b0);
        expect_word(16'hBEEF);
        put(2'b00, 16'hBEEF, 2'b00);
        chk("relock", link_o, 1'b1);
        idle0(3);

        chk("sb_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
